subkey_collector: RTL and testbench



---
 rtl/subkey_collector.sv | 109 ++++++++++
 tb/tb_subkey_collector.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subkey_collector.sv
// rtl/subkey_collector.sv - drains NSRC candidate-subkey FIFOs into one tagged valid/ready stream
// Rotating-priority SCAN/READ/HOLD arbiter; one word in flight at a time.
module subkey_collector #(
    parameter int NSRC = 16,
    parameter int DW   = 24
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NSRC*DW-1:0] SRC_RDDATA,
    input  logic [NSRC-1:0]    SRC_RDEMPTY,
    input  logic [NSRC-1:0]    SRC_DONE,
    output logic [NSRC-1:0]    SRC_RDEN,
    output logic [DW-1:0]      OUT_DATA,
    output logic [3:0]         OUT_SRC,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic               ALL_DONE,
    output logic [31:0]        COUNT
);

    typedef enum logic [1:0] {SCAN, READ, HOLD} state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] ptr;
    logic [3:0] sel;
    logic [3:0] sel_q;
    logic [4:0] idx;
    logic       found;
    logic       any_avail;

    assign any_avail = ~&SRC_RDEMPTY;

    // First non-empty source at or after ptr, wrapping modulo NSRC.
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NSRC; k++) begin
            idx = {1'b0, ptr} + 5'(k);
            if (idx >= 5'(NSRC))
                idx = idx - 5'(NSRC);
            if (!found && !SRC_RDEMPTY[idx[3:0]]) begin
                sel   = idx[3:0];
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= SCAN;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            SCAN:    if (any_avail) next_state = READ;
            READ:    next_state = HOLD;
            HOLD:    if (OUT_READY) next_state = SCAN;
            default: next_state = SCAN;
        endcase
    end

    // Pop strobe is combinational so RDEN and the registered FIFO read line up with READ.
    always_comb begin
        SRC_RDEN = '0;
        if (!RESET && state == SCAN && any_avail)
            SRC_RDEN[sel] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr       <= '0;
            sel_q     <= '0;
            OUT_DATA  <= '0;
            OUT_SRC   <= '0;
            OUT_VALID <= 1'b0;
            COUNT     <= '0;
            ALL_DONE  <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (any_avail) begin
                        sel_q <= sel;
                        ptr   <= (sel == 4'(NSRC - 1)) ? 4'd0 : sel + 4'd1;
                    end
                end
                READ: begin
                    OUT_DATA  <= SRC_RDDATA[sel_q*DW +: DW];
                    OUT_SRC   <= sel_q;
                    OUT_VALID <= 1'b1;
                end
                HOLD: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        if (COUNT != 32'hFFFF_FFFF)
                            COUNT <= COUNT + 32'd1;
                    end
                end
                default: ;
            endcase
            ALL_DONE <= (state == SCAN) && (&SRC_DONE) && (&SRC_RDEMPTY) && !OUT_VALID;
        end
    end

endmodule

// File: tb/tb_subkey_collector.sv
// tb/tb_subkey_collector.sv - directed and randomized bench for subkey_collector
// FIFO model plus expected-order scoreboard derived from rotating-priority rules.
module tb_subkey_collector;

    localparam int N = 16;
    localparam int W = 24;

    logic           CLK = 1'b0;
    logic           RESET;
    logic [N*W-1:0] rddata;
    logic [N-1:0]   empty;
    logic [N-1:0]   done;
    logic [N-1:0]   rden;
    logic [W-1:0]   out_data;
    logic [3:0]     out_src;
    logic           out_valid;
    logic           out_ready;
    logic           all_done;
    logic [31:0]    count;

    subkey_collector #(.NSRC(N), .DW(W)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SRC_RDDATA (rddata),
        .SRC_RDEMPTY(empty),
        .SRC_DONE   (done),
        .SRC_RDEN   (rden),
        .OUT_DATA   (out_data),
        .OUT_SRC    (out_src),
        .OUT_VALID  (out_valid),
        .OUT_READY  (out_ready),
        .ALL_DONE   (all_done),
        .COUNT      (count)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         failures = 0;
    logic [W-1:0] fq [N][$];
    int         exp_src[$];
    logic [W-1:0] exp_data[$];
    int         acc_src[$];
    int         mptr, mcount, pend, pend_src, pop_idx, rden_pulses, ready_mode;
    bit         hold_prev;
    logic [W-1:0] hold_data;
    logic [3:0] hold_src;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic refresh_empty();
        for (int i = 0; i < N; i++)
            empty[i] = (fq[i].size() == 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++)
            fq[i].delete();
        exp_src.delete();
        exp_data.delete();
        acc_src.delete();
        mptr = 0;
        mcount = 0;
        pend = 0;
        pop_idx = -1;
        hold_prev = 0;
        rddata = '0;
        refresh_empty();
    endtask

    // Expected delivery order for the words currently queued, assuming none arrive meanwhile.
    task automatic build_expected();
        int cnt[N];
        int pos[N];
        int rem;
        int i;
        rem = 0;
        for (int s = 0; s < N; s++) begin
            cnt[s] = fq[s].size();
            pos[s] = 0;
            rem += cnt[s];
        end
        while (rem > 0) begin
            for (int k = 0; k < N; k++) begin
                i = (mptr + k) % N;
                if (cnt[i] > 0) begin
                    exp_src.push_back(i);
                    exp_data.push_back(fq[i][pos[i]]);
                    pos[i]++;
                    cnt[i]--;
                    rem--;
                    mptr = (i + 1) % N;
                    break;
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                chk("latency_valid", out_valid, 1);
                chk("latency_src", out_src, pend_src);
            end
        end
        chk("rden_onehot", $onehot0(rden), 1);
        chk("rden_to_empty", rden & empty, 0);
        chk("count", count, mcount);
        if (hold_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, hold_data);
            chk("hold_src", out_src, hold_src);
        end
        hold_prev = out_valid && !out_ready;
        hold_data = out_data;
        hold_src  = out_src;
        if (out_valid && out_ready) begin
            if (exp_src.size() == 0) begin
                chk("unexpected_word", out_src, 32'hDEAD);
            end else begin
                chk("word_src", out_src, exp_src.pop_front());
                chk("word_data", out_data, exp_data.pop_front());
            end
            acc_src.push_back(int'(out_src));
            mcount++;
        end
        pop_idx = -1;
        for (int i = 0; i < N; i++)
            if (rden[i]) pop_idx = i;
        if (pop_idx >= 0) begin
            rden_pulses++;
            pend = 2;
            pend_src = pop_idx;
        end
        @(posedge CLK);
        #1;
        if (pop_idx >= 0 && fq[pop_idx].size() > 0)
            rddata[pop_idx*W +: W] = fq[pop_idx].pop_front();
        refresh_empty();
    endtask

    task automatic run_drain(input int max_cycles);
        int c;
        c = 0;
        while ((exp_src.size() > 0 || out_valid) && c < max_cycles) begin
            cyc();
            c++;
        end
        chk("drain_timeout", exp_src.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int want[6];
        int total;
        int c;
        int base;
        want = '{0, 3, 15, 0, 3, 15};
        RESET = 1'b1;
        done = '0;
        out_ready = 1'b0;
        ready_mode = 0;
        rden_pulses = 0;
        clear_model();

        // Reset held, then 20 idle cycles
        @(posedge CLK);
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_rden", rden, 0);
        chk("reset_all_done", all_done, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("idle_data", out_data, 0);
            chk("idle_src", out_src, 0);
            chk("idle_valid", out_valid, 0);
            chk("idle_all_done", all_done, 0);
        end
        chk("idle_pulses", rden_pulses, 0);

        // Single source 5
        fq[5].push_back(24'hABCDEF);
        refresh_empty();
        build_expected();
        run_drain(20);
        chk("single_pulses", rden_pulses, 1);
        chk("single_count", count, 1);

        // Round-robin after reset: sources 0, 3, 15 with two words each
        RESET = 1'b1;
        clear_model();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        for (int r = 0; r < 2; r++) begin
            fq[0].push_back(W'($urandom));
            fq[3].push_back(W'($urandom));
            fq[15].push_back(W'($urandom));
        end
        refresh_empty();
        build_expected();
        run_drain(40);
        chk("rr_len", acc_src.size(), 6);
        for (int k = 0; k < 6; k++)
            chk("rr_order", (acc_src.size() > k) ? acc_src[k] : 99, want[k]);
        chk("rr_count", count, 6);

        // Backpressure for 50 cycles
        rden_pulses = 0;
        ready_mode = 2;
        fq[2].push_back(24'h123456);
        refresh_empty();
        build_expected();
        repeat (50) cyc();
        chk("bp_pulses", rden_pulses, 1);
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, 24'h123456);
        ready_mode = 0;
        run_drain(10);
        chk("bp_count", count, 7);
        chk("bp_pulses_after", rden_pulses, 1);

        // Randomized load with random backpressure
        ready_mode = 1;
        for (int round = 0; round < 3; round++) begin
            total = 0;
            for (int s = 0; s < N; s++) begin
                c = $urandom_range(0, 3);
                for (int w = 0; w < c; w++)
                    fq[s].push_back(W'($urandom));
                total += c;
            end
            base = mcount;
            refresh_empty();
            build_expected();
            run_drain(800);
            chk("rand_count", count, base + total);
        end

        // Completion with three words outstanding
        ready_mode = 0;
        done = '1;
        fq[1].push_back(W'($urandom));
        fq[7].push_back(W'($urandom));
        fq[9].push_back(W'($urandom));
        refresh_empty();
        build_expected();
        base = acc_src.size();
        c = 0;
        while (acc_src.size() - base < 3 && c < 40) begin
            chk("all_done_early", all_done, 0);
            cyc();
            c++;
        end
        chk("done_drain", acc_src.size() - base, 3);
        cyc();
        cyc();
        chk("all_done_set", all_done, 1);
        done[7] = 1'b0;
        cyc();
        chk("all_done_drop", all_done, 0);
        done = '0;

        // Asynchronous reset while a word is held
        ready_mode = 2;
        fq[6].push_back(W'($urandom));
        refresh_empty();
        build_expected();
        c = 0;
        while (!out_valid && c < 10) begin
            cyc();
            c++;
        end
        chk("pre_reset_valid", out_valid, 1);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_count", count, 0);
        chk("async_data", out_data, 0);
        chk("async_rden", rden, 0);
        clear_model();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        ready_mode = 0;
        fq[10].push_back(W'($urandom));
        fq[4].push_back(W'($urandom));
        refresh_empty();
        build_expected();
        run_drain(20);
        chk("restart_first", (acc_src.size() > 0) ? acc_src[0] : 99, 4);
        chk("restart_second", (acc_src.size() > 1) ? acc_src[1] : 99, 10);
        chk("restart_count", count, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
